// File: rtl/unified_mem_arbiter_pkg.sv
// Purpose: shared types and constants for the unified instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, transaction-owner encoding, funct3 used for instruction fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Fetches are always full-word reads.
  localparam logic [2:0] F3_LW = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Purpose: bundles the fetch port, data port, memory port and stall of the unified memory arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; the arbiter drives gnt/rvalid/stall, requesters hold req until rvalid.
// Modports: slave = arbiter side, master = requesters + memory side.
interface unified_mem_arbiter_if;

  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // data port
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // memory port
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_f3;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // pipeline hold
  logic        stall;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_f3, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_f3, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported unified memory between the instruction-fetch and load/store ports.
// Latency: grant is combinational in IDLE; rvalid MEM_LAT cycles after grant; one access per MEM_LAT+1 cycles.
// Backpressure: a waiting or losing requester sees gnt=0 and stall=1 until its own rvalid cycle.
// Ports: clk; rst (async, active-high); bus (slave modport) carrying if_*, d_*, mem_* and stall.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int              CW         = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // ACCESS lasts MEM_LAT-1 cycles, so the counter starts one below that and exits at zero.
  localparam logic [CW-1:0]   CNT_INIT   = CW'(MEM_LAT - 2);
  localparam logic [1:0]      STARVE_LIM = 2'(STARVE_MAX);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  owner_t        r_owner;
  logic          r_store;
  logic [1:0]    r_streak;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_idle;
  logic          w_d_wins;
  logic          w_gnt_if;
  logic          w_gnt_d;
  logic          w_resp;
  logic          w_if_rvalid;
  logic          w_d_rvalid;
  logic          w_unused;

  // Arbitration and completion decode. Grants are masked during reset so that
  // every output is 0 while rst is high, even with requests pending.
  always_comb begin
    w_idle      = (r_state == IDLE) && !rst;
    w_d_wins    = bus.d_req && (!bus.if_req || (r_streak != STARVE_LIM));
    w_gnt_d     = w_idle && w_d_wins;
    w_gnt_if    = w_idle && bus.if_req && !w_d_wins;
    w_resp      = (r_state == RESP);
    w_if_rvalid = w_resp && (r_owner == OWN_IF);
    w_d_rvalid  = w_resp && (r_owner == OWN_D);
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_gnt_if || w_gnt_d) begin
          if (MEM_LAT == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = ACCESS;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_IF;
      r_store    <= 1'b0;
      r_streak   <= 2'd0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      if (w_gnt_if) begin
        r_owner <= OWN_IF;
        r_store <= 1'b0;
      end else if (w_gnt_d) begin
        r_owner <= OWN_D;
        r_store <= bus.d_we;
      end
      // Streak counts data wins only while a fetch is actually waiting.
      if (w_idle) begin
        if (w_gnt_if || !bus.if_req) begin
          r_streak <= 2'd0;
        end else if (w_gnt_d && (r_streak != 2'd3)) begin
          r_streak <= r_streak + 2'd1;
        end
      end
      if (w_if_rvalid) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_d_rvalid && !r_store) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  // Memory port: live only in the grant cycle, otherwise all zero.
  assign bus.if_gnt    = w_gnt_if;
  assign bus.d_gnt     = w_gnt_d;
  assign bus.mem_en    = w_gnt_if || w_gnt_d;
  assign bus.mem_we    = w_gnt_d && bus.d_we;
  assign bus.mem_f3    = w_gnt_if ? F3_LW : (w_gnt_d ? bus.d_funct3 : 3'b000);
  assign bus.mem_addr  = w_gnt_if ? bus.if_addr[7:2] : (w_gnt_d ? bus.d_addr[7:2] : 6'd0);
  assign bus.mem_wdata = w_gnt_d ? bus.d_wdata : 32'd0;

  // Read data is forwarded in the RESP cycle and held from the register afterwards.
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : r_if_rdata;
  assign bus.d_rdata   = (w_d_rvalid && !r_store) ? bus.mem_rdata : r_d_rdata;

  assign bus.stall = !rst && ((bus.if_req && !w_if_rvalid) || (bus.d_req && !w_d_rvalid));

  // Only address bits [7:2] select a word; the 256-byte space wraps.
  assign w_unused = ^{bus.if_addr[31:8], bus.if_addr[1:0], bus.d_addr[31:8], bus.d_addr[1:0]};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose: self-checking bench for unified_mem_arbiter at MEM_LAT=1 and MEM_LAT=3 (STARVE_MAX=2).
// Latency: n/a.
// Backpressure: requesters hold req through rvalid; a memory model returns data MEM_LAT cycles after mem_en.
module tb_unified_mem_arbiter;

  localparam int STARVE = 2;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rv;
    logic        d_rv;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
    logic        en;
    logic        we;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        stall;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_f3;

  unified_mem_arbiter_if bus_a ();
  unified_mem_arbiter_if bus_b ();

  unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  unified_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Memory devices: one word array and one read delay line per DUT.
  logic [31:0] mem [2][64];
  logic [31:0] dl  [2][4];

  assign bus_a.if_req = if_req;  assign bus_b.if_req = if_req;
  assign bus_a.if_addr = if_addr; assign bus_b.if_addr = if_addr;
  assign bus_a.d_req = d_req;    assign bus_b.d_req = d_req;
  assign bus_a.d_we = d_we;      assign bus_b.d_we = d_we;
  assign bus_a.d_funct3 = d_f3;  assign bus_b.d_funct3 = d_f3;
  assign bus_a.d_addr = d_addr;  assign bus_b.d_addr = d_addr;
  assign bus_a.d_wdata = d_wdata; assign bus_b.d_wdata = d_wdata;
  assign bus_a.mem_rdata = dl[0][0];
  assign bus_b.mem_rdata = dl[1][2];

  obs_t oa, ob;
  assign oa = '{if_gnt: bus_a.if_gnt, d_gnt: bus_a.d_gnt, if_rv: bus_a.if_rvalid, d_rv: bus_a.d_rvalid,
                if_rdata: bus_a.if_rdata, d_rdata: bus_a.d_rdata, en: bus_a.mem_en, we: bus_a.mem_we,
                f3: bus_a.mem_f3, addr: bus_a.mem_addr, wdata: bus_a.mem_wdata, stall: bus_a.stall};
  assign ob = '{if_gnt: bus_b.if_gnt, d_gnt: bus_b.d_gnt, if_rv: bus_b.if_rvalid, d_rv: bus_b.d_rvalid,
                if_rdata: bus_b.if_rdata, d_rdata: bus_b.d_rdata, en: bus_b.mem_en, we: bus_b.mem_we,
                f3: bus_b.mem_f3, addr: bus_b.mem_addr, wdata: bus_b.mem_wdata, stall: bus_b.stall};

  int n_checks = 0;
  int n_err    = 0;
  int t        = 0;
  int sel      = 0;   // which DUT is being checked
  int L        = 1;   // its memory latency

  // Reference model: transaction timeline expressed in absolute cycle numbers.
  int          next_idle, resp_t, streak;
  logic        m_own_d, m_store;
  logic [31:0] m_data, if_hold, d_hold;
  logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;

  // Observation logs for directed checks.
  logic [5:0]  order;
  int          ngrant, gnt_prev_t, gnt_t, rv_t, n_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    obs_t        o;
    obs_t        cap [2];
    logic        idle, dw;
    logic [31:0] ga, e_if_rdata, e_d_rdata;
    logic        e_stall;
    @(negedge clk);
    o      = (sel == 1) ? ob : oa;
    cap[0] = oa;
    cap[1] = ob;
    e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
    e_if_rdata = 32'd0; e_d_rdata = 32'd0; e_stall = 1'b0;
    ga = e_d_gnt ? d_addr : if_addr;
    if (rst) begin
      next_idle = t + 1; resp_t = -1; streak = 0;
      if_hold = 32'd0; d_hold = 32'd0; m_own_d = 1'b0; m_store = 1'b0;
    end else begin
      idle = (t >= next_idle);
      if (idle) begin
        dw       = d_req && (!if_req || streak != STARVE);
        e_d_gnt  = dw;
        e_if_gnt = if_req && !dw;
      end
      e_if_rv    = (t == resp_t) && !m_own_d;
      e_d_rv     = (t == resp_t) && m_own_d;
      e_if_rdata = e_if_rv ? m_data : if_hold;
      e_d_rdata  = (e_d_rv && !m_store) ? m_data : d_hold;
      e_stall    = (if_req && !e_if_rv) || (d_req && !e_d_rv);
      if_hold    = e_if_rdata;
      d_hold     = e_d_rdata;
      ga = e_d_gnt ? d_addr : if_addr;
      if (e_if_gnt || e_d_gnt) begin
        resp_t    = t + L;
        next_idle = t + L + 1;
        m_own_d   = e_d_gnt;
        m_store   = e_d_gnt && d_we;
        m_data    = mem[sel][ga[7:2]];
      end
      if (idle) begin
        if (e_if_gnt || !if_req) streak = 0;
        else if (e_d_gnt && streak < 3) streak++;
      end
    end
    chk("if_gnt",    32'(o.if_gnt), 32'(e_if_gnt));
    chk("d_gnt",     32'(o.d_gnt), 32'(e_d_gnt));
    chk("if_rvalid", 32'(o.if_rv), 32'(e_if_rv));
    chk("d_rvalid",  32'(o.d_rv), 32'(e_d_rv));
    chk("if_rdata",  o.if_rdata, e_if_rdata);
    chk("d_rdata",   o.d_rdata, e_d_rdata);
    chk("mem_en",    32'(o.en), 32'(e_if_gnt || e_d_gnt));
    chk("mem_we",    32'(o.we), 32'(e_d_gnt && d_we));
    chk("mem_f3",    32'(o.f3), e_if_gnt ? 32'd2 : (e_d_gnt ? 32'(d_f3) : 32'd0));
    chk("mem_addr",  32'(o.addr), (e_if_gnt || e_d_gnt) ? 32'(ga[7:2]) : 32'd0);
    chk("mem_wdata", o.wdata, e_d_gnt ? d_wdata : 32'd0);
    chk("stall",     32'(o.stall), 32'(e_stall));
    if (o.if_gnt || o.d_gnt) begin
      order = {order[4:0], o.d_gnt};
      ngrant++;
    end
    if (o.if_gnt) begin gnt_prev_t = gnt_t; gnt_t = t; end
    if (o.if_rv) rv_t = t;
    if (o.if_rv || o.d_rv) n_rv++;
    t++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) dl[k][j] = dl[k][j-1];
      dl[k][0] = cap[k].en ? mem[k][cap[k].addr] : $urandom;
      if (cap[k].en && cap[k].we) mem[k][cap[k].addr] = cap[k].wdata;
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_f3 = 3'd0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  // Random requesters obeying the hold-until-rvalid protocol.
  task automatic rand_phase(input int n);
    logic if_on, if_g, d_on, d_g;
    if_on = 1'b0; if_g = 1'b0; d_on = 1'b0; d_g = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!if_on) begin
        if ($urandom_range(1, 0) == 1) begin if_on = 1'b1; if_addr = $urandom; end
      end else if (!if_g && $urandom_range(7, 0) == 0) if_on = 1'b0;
      if (!d_on) begin
        if ($urandom_range(1, 0) == 1) begin
          d_on = 1'b1; d_addr = $urandom; d_wdata = $urandom;
          d_we = 1'($urandom_range(1, 0)); d_f3 = 3'($urandom_range(7, 0));
        end
      end else if (!d_g && $urandom_range(7, 0) == 0) d_on = 1'b0;
      if_req = if_on;
      d_req  = d_on;
      step();
      if (e_if_gnt) if_g = 1'b1;
      if (e_d_gnt) d_g = 1'b1;
      if (e_if_rv) begin
        if_g = 1'b0;
        if ($urandom_range(1, 0) == 1) if_addr = $urandom; else if_on = 1'b0;
      end
      if (e_d_rv) begin
        d_g = 1'b0;
        if ($urandom_range(1, 0) == 1) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1, 0));
        end else d_on = 1'b0;
      end
    end
    idle_inputs();
    repeat (L + 2) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 64; w++) mem[k][w] = $urandom;
      for (int j = 0; j < 4; j++) dl[k][j] = 32'd0;
    end
    order = 6'd0; ngrant = 0; gnt_t = 0; gnt_prev_t = 0; rv_t = 0; n_rv = 0;
    idle_inputs();
    rst = 1'b1;
    #1;

    // ---- MEM_LAT = 1 ----
    sel = 0; L = 1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // single fetch from 0x10
    if_req = 1'b1; if_addr = 32'h0000_0010;
    repeat (2) step();
    if_req = 1'b0;
    step();

    // simultaneous load and fetch: data first, fetch at +2
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'hFFFF_FF88;
    repeat (2) step();
    d_req = 1'b0;
    repeat (2) step();
    if_req = 1'b0;
    step();

    // starvation guard with both ports held high
    order = 6'd0; ngrant = 0;
    if_req = 1'b1; if_addr = 32'h0000_00A0;
    d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b100; d_addr = 32'h0000_0030;
    repeat (12) step();
    chk("starve_order", 32'(order), 32'b110110);
    chk("starve_grants", ngrant, 6);
    idle_inputs();
    repeat (2) step();

    // store 0xDEADBEEF to 0x24 as a byte-size access
    d_req = 1'b1; d_we = 1'b1; d_f3 = 3'b000; d_addr = 32'h0000_0024; d_wdata = 32'hDEAD_BEEF;
    repeat (2) step();
    d_req = 1'b0;
    step();
    chk("store_written", mem[0][9], 32'hDEAD_BEEF);

    rand_phase(300);

    // ---- MEM_LAT = 3 ----
    sel = 1; L = 3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // back-to-back fetches: rvalid 3 after grant, regrant 4 after grant
    if_req = 1'b1; if_addr = 32'h0000_1234;
    repeat (8) step();
    chk("lat3_rvalid_gap", rv_t - gnt_t, 3);
    chk("lat3_regrant_gap", gnt_t - gnt_prev_t, 4);
    if_req = 1'b0;
    step();

    // reset in ACCESS: outputs drop at once, no completion follows
    if_req = 1'b1; if_addr = 32'h0000_0008;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0;
    n_rv = 0;
    repeat (5) step();
    chk("no_rvalid_after_rst", n_rv, 0);

    rand_phase(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
